xfft_sdf_stage: RTL and testbench

XFFT_SDF_STAGE -- requirements
Module: xfft_sdf_stage

---
 rtl/xfft_sdf_stage.sv | 149 ++++++++++++++
 tb/tb_xfft_sdf_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/xfft_sdf_stage.sv
// Purpose: radix-2 single-path delay-feedback (SDF) butterfly stage; optional output register via XFFT_SDF_OREG_EN.
// Latency: 1 cycle i_valid->o_valid with XFFT_SDF_OREG_EN defined, otherwise 0 (combinational outputs).
// Backpressure: none; the stage advances only on i_valid and never stalls upstream.
module xfft_sdf_stage #(
  parameter int NB_I  = 10,
  parameter int NBF_I = 7,
  parameter int NB_O  = 11,
  parameter int DELAY = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic signed [NB_I-1:0]     i_data_r,
  input  logic signed [NB_I-1:0]     i_data_i,
  output logic signed [NB_O-1:0]     o_data_r,
  output logic signed [NB_O-1:0]     o_data_i,
  output logic                       o_valid,
  output logic                       o_tw_en,
  output logic [$clog2(DELAY)-1:0]   o_tw_idx
);

  localparam int KW = $clog2(DELAY);
  localparam int CW = KW + 1;

  // Elaboration-time parameter sanity checks
  if (NB_O != NB_I + 1) begin : g_bad_nb_o
    $error("NB_O must equal NB_I+1");
  end
  if (NBF_I >= NB_I) begin : g_bad_nbf_i
    $error("NBF_I must be smaller than NB_I");
  end
  if (DELAY < 2 || (DELAY & (DELAY - 1)) != 0) begin : g_bad_delay
    $error("DELAY must be a power of two, at least 2");
  end

  logic [CW-1:0]          cnt;
  logic                   pending;
  logic                   phase;
  logic [KW-1:0]          k;
  logic signed [NB_O-1:0] dl_r [DELAY];
  logic signed [NB_O-1:0] dl_i [DELAY];
  logic signed [NB_O-1:0] in_r, in_i;
  logic signed [NB_O-1:0] head_r, head_i;
  logic signed [NB_O-1:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [NB_O-1:0] wr_r, wr_i;
  logic signed [NB_O-1:0] nx_r, nx_i;
  logic                   nx_valid;
  logic                   nx_tw_en;
  logic [KW-1:0]          nx_tw_idx;

  assign phase  = cnt[KW];
  assign k      = cnt[KW-1:0];
  assign in_r   = NB_O'(i_data_r);
  assign in_i   = NB_O'(i_data_i);
  assign head_r = dl_r[DELAY-1];
  assign head_i = dl_i[DELAY-1];

  // Butterfly arithmetic at full NB_O precision; no rounding, no saturation
  always_comb begin
    sum_r     = head_r + in_r;
    sum_i     = head_i + in_i;
    dif_r     = head_r - in_r;
    dif_i     = head_i - in_i;
    wr_r      = phase ? dif_r : in_r;
    wr_i      = phase ? dif_i : in_i;
    nx_r      = phase ? sum_r : head_r;
    nx_i      = phase ? sum_i : head_i;
    nx_valid  = phase | pending;
    nx_tw_en  = ~phase;
    nx_tw_idx = phase ? '0 : k;
  end

  // Sample counter and pending-difference flag, advanced only by valid samples
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (i_valid) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        pending <= 1'b1;
      end else if (cnt == CW'(DELAY - 1)) begin
        pending <= 1'b0;
      end
    end
  end

  // Delay line: unreset shift register; stale contents are masked by pending=0
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      dl_r[0] <= wr_r;
      dl_i[0] <= wr_i;
      for (int j = 1; j < DELAY; j++) begin
        dl_r[j] <= dl_r[j-1];
        dl_i[j] <= dl_i[j-1];
      end
    end
  end

`ifdef XFFT_SDF_OREG_EN
  // Registered outputs: data and twiddle fields update on valid, held otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_tw_en  <= 1'b0;
      o_tw_idx <= '0;
      o_data_r <= '0;
      o_data_i <= '0;
    end else begin
      o_valid <= i_valid & nx_valid;
      if (i_valid) begin
        o_tw_en  <= nx_tw_en;
        o_tw_idx <= nx_tw_idx;
        o_data_r <= nx_r;
        o_data_i <= nx_i;
      end
    end
  end
`else
  logic signed [NB_O-1:0] hold_r, hold_i;
  logic                   hold_tw_en;
  logic [KW-1:0]          hold_tw_idx;

  // Last emitted values, so data stays put while i_valid is low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_r      <= '0;
      hold_i      <= '0;
      hold_tw_en  <= 1'b0;
      hold_tw_idx <= '0;
    end else if (i_valid) begin
      hold_r      <= nx_r;
      hold_i      <= nx_i;
      hold_tw_en  <= nx_tw_en;
      hold_tw_idx <= nx_tw_idx;
    end
  end

  // Combinational outputs: live result on valid, held result in gaps
  always_comb begin
    o_valid  = i_valid & nx_valid;
    o_data_r = i_valid ? nx_r : hold_r;
    o_data_i = i_valid ? nx_i : hold_i;
    o_tw_en  = i_valid ? nx_tw_en : hold_tw_en;
    o_tw_idx = i_valid ? nx_tw_idx : hold_tw_idx;
  end
`endif

endmodule

// File: tb/tb_xfft_sdf_stage.sv
// Directed table-driven bench for xfft_sdf_stage with DELAY=4, NB_I=10.
// Results are sampled one cycle after the input with the output register, or in the same cycle without it.
// Hand-written sequences cover reset state and reset asserted mid-frame.
module tb_xfft_sdf_stage;

  localparam int NB_I  = 10;
  localparam int NBF_I = 7;
  localparam int NB_O  = 11;
  localparam int DELAY = 4;
  localparam int KW    = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic                   i_valid = 1'b0;
  logic signed [NB_I-1:0] i_data_r = '0;
  logic signed [NB_I-1:0] i_data_i = '0;
  logic signed [NB_O-1:0] o_data_r, o_data_i;
  logic                   o_valid, o_tw_en;
  logic [KW-1:0]          o_tw_idx;

  int checks = 0;
  int failures = 0;

  xfft_sdf_stage #(.NB_I(NB_I), .NBF_I(NBF_I), .NB_O(NB_O), .DELAY(DELAY)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_data_r(i_data_r), .i_data_i(i_data_i),
    .o_data_r(o_data_r), .o_data_i(o_data_i),
    .o_valid(o_valid), .o_tw_en(o_tw_en), .o_tw_idx(o_tw_idx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic v;
    int   r, i;
    logic ev;
    int   er, ei;
    logic te;
    int   ti;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, int r, int i, logic ev, int er, int ei, logic te, int ti);
    vec_t x;
    x.v = v; x.r = r; x.i = i; x.ev = ev; x.er = er; x.ei = ei; x.te = te; x.ti = ti;
    tbl.push_back(x);
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Drive one row and sample the corresponding output
  task automatic apply(logic v, int r, int i);
    @(negedge i_clk);
    i_valid  = v;
    i_data_r = NB_I'(r);
    i_data_i = NB_I'(i);
`ifdef XFFT_SDF_OREG_EN
    @(posedge i_clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic run_range(int lo, int hi);
    logic last_ev = 1'b0;
    int   last_r = 0, last_i = 0;
    for (int n = lo; n < hi; n++) begin
      apply(tbl[n].v, tbl[n].r, tbl[n].i);
      chk("o_valid", n, int'(o_valid), int'(tbl[n].ev));
      if (tbl[n].ev) begin
        chk("o_data_r", n, int'(o_data_r), tbl[n].er);
        chk("o_data_i", n, int'(o_data_i), tbl[n].ei);
        chk("o_tw_en", n, int'(o_tw_en), int'(tbl[n].te));
        chk("o_tw_idx", n, int'(o_tw_idx), tbl[n].ti);
      end else if (!tbl[n].v && last_ev) begin
        chk("hold_data_r", n, int'(o_data_r), last_r);
        chk("hold_data_i", n, int'(o_data_i), last_i);
      end
      if (tbl[n].v) begin
        last_ev = tbl[n].ev;
        last_r  = tbl[n].er;
        last_i  = tbl[n].ei;
      end
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, -1, int'(o_valid), 0);
    chk({tag, "_data_r"}, -1, int'(o_data_r), 0);
    chk({tag, "_data_i"}, -1, int'(o_data_i), 0);
    chk({tag, "_tw_en"}, -1, int'(o_tw_en), 0);
    chk({tag, "_tw_idx"}, -1, int'(o_tw_idx), 0);
  endtask

  int seg1_end, seg2_end, seg3_end;

  initial begin
    // Segment 1: frames 1..6
    // frame 1: fill, then sums
    for (int n = 0; n < 4; n++) add(1, n + 1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) add(1, 10 * (n + 1), 0, 1, 11 * (n + 1), 0, 0, 0);
    // frame 2: zeros pull out differences -9.. -36
    for (int n = 0; n < 4; n++) add(1, 0, 0, 1, -9 * (n + 1), 0, 1, n);
    for (int n = 0; n < 4; n++) add(1, 0, 0, 1, 0, 0, 0, 0);
    // frame 3: frame 1 again with a gap after every sample
    for (int n = 0; n < 4; n++) begin
      add(1, n + 1, 0, 1, 0, 0, 1, n);
      add(0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int n = 0; n < 4; n++) begin
      add(1, 10 * (n + 1), 0, 1, 11 * (n + 1), 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
    end
    // frame 4: extremes in FILL, gap-paired differences emitted
    add(1, -512, 0, 1, -9, 0, 1, 0);
    add(1, 511, 0, 1, -18, 0, 1, 1);
    add(1, 0, 0, 1, -27, 0, 1, 2);
    add(1, 0, 0, 1, -36, 0, 1, 3);
    add(1, -512, 0, 1, -1024, 0, 0, 0);
    add(1, -512, 0, 1, -1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    // frame 5: complex fill, extreme differences emitted
    add(1, 3, -5, 1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1023, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 1, 2);
    add(1, 0, 0, 1, 0, 0, 1, 3);
    add(1, 1, 2, 1, 4, -3, 0, 0);
    for (int n = 0; n < 3; n++) add(1, 0, 0, 1, 0, 0, 0, 0);
    // frame 6: complex difference emitted
    add(1, 0, 0, 1, 2, -7, 1, 0);
    for (int n = 1; n < 4; n++) add(1, 0, 0, 1, 0, 0, 1, n);
    for (int n = 0; n < 4; n++) add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    seg1_end = tbl.size();
    // Segment 2: six samples of a partial frame before reset
    for (int n = 0; n < 4; n++) add(1, n + 1, 0, 1, 0, 0, 1, n);
    add(1, 10, 0, 1, 11, 0, 0, 0);
    add(1, 20, 0, 1, 22, 0, 0, 0);
    seg2_end = tbl.size();
    // Segment 3: after mid-frame reset, a fresh frame
    for (int n = 0; n < 4; n++) add(1, n + 5, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) add(1, 100 * (n + 1), 0, 1, 100 * (n + 1) + n + 5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    seg3_end = tbl.size();

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    run_range(0, seg1_end);
    run_range(seg1_end, seg2_end);

    // Asynchronous reset mid-frame: outputs clear immediately
    #2;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;

    run_range(seg2_end, seg3_end);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
